// File: rtl/task_launch_fifo.sv
// Task launch queue: accepts launch requests for one channel parity into a
// circular FIFO and presents the head entry combinationally to the fetcher.
module task_launch_fifo #(
  parameter int CHAN_SEL_SIZE   = 3,
  parameter int THREAD_SEL_SIZE = 2,
  parameter int OPERAND_SIZE    = 8,
  parameter int DEPTH_LOG2      = 3,
  parameter int QUEUE_SEL       = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  input  logic [CHAN_SEL_SIZE:0]     req_channel,
  input  logic [THREAD_SEL_SIZE-1:0] req_thread,
  input  logic [OPERAND_SIZE-1:0]    req_operand,
  output logic                       req_accept,
  output logic [CHAN_SEL_SIZE-1:0]   next_task_channel,
  output logic [THREAD_SEL_SIZE-1:0] next_task_thread,
  output logic [OPERAND_SIZE-1:0]    next_task_operand,
  output logic                       next_task_ready,
  input  logic                       next_task_ack,
  output logic [DEPTH_LOG2:0]        fifo_count,
  output logic                       fifo_full,
  output logic                       overflow,
  output logic                       bad_request,
  input  logic                       clear_flags
);
  localparam int                         DEPTH       = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]        FULL_CNT    = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [THREAD_SEL_SIZE-1:0] RSVD_THREAD = THREAD_SEL_SIZE'(3);
  localparam logic                       QSEL        = 1'(QUEUE_SEL);

  logic [CHAN_SEL_SIZE-1:0]   chan_mem    [DEPTH];
  logic [THREAD_SEL_SIZE-1:0] thread_mem  [DEPTH];
  logic [OPERAND_SIZE-1:0]    operand_mem [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  accept_q, overflow_q, bad_q;
  logic                  match, eligible, reject, is_full, pop, push, drop;

  assign match    = req_valid && (req_channel[0] == QSEL);
  assign eligible = match && (req_thread != RSVD_THREAD);
  assign reject   = match && (req_thread == RSVD_THREAD);
  assign is_full  = (count == FULL_CNT);
  assign pop      = next_task_ack && (count != '0);
  // A pop on a full FIFO frees the slot the push lands in on the same edge.
  assign push     = eligible && (!is_full || pop);
  assign drop     = eligible && !push;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      accept_q   <= 1'b0;
      overflow_q <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      accept_q <= push;
      // Clearing wins over a flag raised in the same cycle.
      if (clear_flags) begin
        overflow_q <= 1'b0;
        bad_q      <= 1'b0;
      end else begin
        if (drop)   overflow_q <= 1'b1;
        if (reject) bad_q      <= 1'b1;
      end
    end
  end

  // Storage is never cleared; head data is only meaningful while ready.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      chan_mem[wr_ptr]    <= req_channel[CHAN_SEL_SIZE:1];
      thread_mem[wr_ptr]  <= req_thread;
      operand_mem[wr_ptr] <= req_operand;
    end
  end

  assign next_task_channel = chan_mem[rd_ptr];
  assign next_task_thread  = thread_mem[rd_ptr];
  assign next_task_operand = operand_mem[rd_ptr];

  // Status reads as idle for the whole reset cycle, not only after the edge.
  assign next_task_ready = !reset && (count != '0);
  assign fifo_full       = !reset && is_full;
  assign fifo_count      = reset ? '0 : count;
  assign req_accept      = !reset && accept_q;
  assign overflow        = !reset && overflow_q;
  assign bad_request     = !reset && bad_q;
endmodule

// File: tb/tb_task_launch_fifo.sv
// Scoreboard bench for task_launch_fifo: a queue-based reference model
// tracks accepted entries; a negedge monitor checks status and head data.
module tb_task_launch_fifo;
  logic       clk, reset, req_valid, next_task_ack, clear_flags;
  logic [3:0] req_channel;
  logic [1:0] req_thread;
  logic [7:0] req_operand;
  logic       req_accept, next_task_ready, fifo_full, overflow, bad_request;
  logic [2:0] next_task_channel;
  logic [1:0] next_task_thread;
  logic [7:0] next_task_operand;
  logic [3:0] fifo_count;

  task_launch_fifo dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_channel(req_channel),
    .req_thread(req_thread), .req_operand(req_operand), .req_accept(req_accept),
    .next_task_channel(next_task_channel), .next_task_thread(next_task_thread),
    .next_task_operand(next_task_operand), .next_task_ready(next_task_ready),
    .next_task_ack(next_task_ack), .fifo_count(fifo_count), .fifo_full(fifo_full),
    .overflow(overflow), .bad_request(bad_request), .clear_flags(clear_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] ch;
    logic [1:0] th;
    logic [7:0] op;
  } ent_t;

  ent_t exp_q[$];
  int   m_count = 0;
  bit   m_acc = 0, m_ovf = 0, m_bad = 0, started = 0;
  int   n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of 8, rules applied per cycle on sampled inputs.
  always @(posedge clk) begin
    bit pop, match, elig, push;
    if (reset) begin
      exp_q.delete();
      m_count = 0; m_acc = 0; m_ovf = 0; m_bad = 0;
    end else begin
      pop   = next_task_ack && (m_count > 0);
      match = req_valid && (req_channel[0] == 1'b0);
      elig  = match && (req_thread != 2'd3);
      push  = elig && ((m_count < 8) || pop);
      if (pop) m_count--;
      if (push) begin
        m_count++;
        exp_q.push_back('{ch: req_channel[3:1], th: req_thread, op: req_operand});
      end
      m_acc = push;
      if (clear_flags) begin
        m_ovf = 0; m_bad = 0;
      end else begin
        if (elig && !push) m_ovf = 1;
        if (match && req_thread == 2'd3) m_bad = 1;
      end
    end
    started = 1;
  end

  // Monitor: compares status every cycle and head data whenever presented.
  always @(negedge clk) begin
    if (started) begin
      bit rdy;
      rdy = !reset && (m_count > 0);
      chk("ready",    next_task_ready, rdy);
      chk("count",    fifo_count, reset ? 0 : m_count);
      chk("full",     fifo_full, !reset && (m_count == 8));
      chk("accept",   req_accept, !reset && m_acc);
      chk("overflow", overflow, !reset && m_ovf);
      chk("bad_req",  bad_request, !reset && m_bad);
      if (rdy) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_nonempty", 0, 1);
        end else begin
          chk("head_channel", next_task_channel, exp_q[0].ch);
          chk("head_thread",  next_task_thread,  exp_q[0].th);
          chk("head_operand", next_task_operand, exp_q[0].op);
          if (next_task_ack) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [3:0] ch, input logic [1:0] th,
                     input logic [7:0] op, input logic ak, input logic cl);
    req_valid = v; req_channel = ch; req_thread = th; req_operand = op;
    next_task_ack = ak; clear_flags = cl;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cyc(0, 4'd0, 2'd0, 8'd0, 0, 0);
  endtask

  task automatic push_rand(input logic ak);
    cyc(1, {3'($urandom), 1'b0}, 2'($urandom_range(0, 2)), 8'($urandom), ak, 0);
  endtask

  task automatic ack_n(input int n);
    for (int i = 0; i < n; i++) cyc(0, 4'd0, 2'd0, 8'd0, 1, 0);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 0; req_channel = 0; req_thread = 0; req_operand = 0;
    next_task_ack = 0; clear_flags = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic push: channel 6 -> head channel 3
    cyc(1, 4'b0110, 2'd1, 8'hA5, 0, 0);
    idle();
    ack_n(1);
    idle();

    // Fill to 8, then overflow, then clear
    for (int i = 0; i < 8; i++) push_rand(0);
    push_rand(0);
    idle();
    cyc(0, 4'd0, 2'd0, 8'd0, 0, 1);
    // Push with pop on full: count holds, no overflow; then drain in order
    push_rand(1);
    ack_n(8);
    ack_n(1);
    idle();

    // Reserved thread and foreign channel
    cyc(1, 4'b0100, 2'd3, 8'h11, 0, 0);
    idle();
    cyc(0, 4'd0, 2'd0, 8'd0, 0, 1);
    cyc(1, 4'b0011, 2'd1, 8'h22, 0, 0);
    idle();
    // Flag set and clear in the same cycle: clear wins
    cyc(1, 4'b0010, 2'd3, 8'h33, 0, 1);
    idle();

    // Wrap-around: 5 in, 5 out, 6 in, 6 out, ack on empty
    for (int i = 0; i < 5; i++) push_rand(0);
    ack_n(5);
    for (int i = 0; i < 6; i++) push_rand(0);
    ack_n(6);
    ack_n(2);
    // Push and ack together on empty: pop ignored
    push_rand(1);
    ack_n(1);

    // Reset with entries queued; request/ack in reset cycle ignored
    for (int i = 0; i < 4; i++) push_rand(0);
    reset = 1'b1;
    push_rand(1);
    reset = 1'b0;
    idle();
    push_rand(0);
    idle();
    ack_n(1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 249) == 0);
      cyc(($urandom_range(0, 3) != 0), 4'($urandom), 2'($urandom), 8'($urandom),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
    end
    reset = 1'b0;
    ack_n(10);

    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
